// File: rtl/osd_text_writer_pkg.sv
// Shared opcodes, FSM states, geometry and the nibble-to-ASCII helper
// for the OSD text writer and its character buffer.
package osd_pkg;

  typedef enum logic [1:0] {
    OP_PUTC   = 2'd0,
    OP_SETPOS = 2'd1,
    OP_HEX    = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HEX   = 2'd2
  } state_e;

  localparam int unsigned OSD_COLS  = 16;
  localparam int unsigned OSD_ROWS  = 8;
  localparam int unsigned OSD_CELLS = 128;

  localparam logic [7:0] NEWLINE = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/osd_text_writer_ram.sv
// 128x8 simple dual-port character buffer: one write port, one registered
// read port with read-before-write behaviour on address collisions.
module osd_text_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:127];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/osd_text_writer.sv
// Command-driven writer for the 16x8 debug OSD character buffer: clear,
// put character, set cursor and print hex, plus the renderer read port.
module osd_text_writer
  import osd_pkg::*;
#(
  parameter int unsigned COLS      = OSD_COLS,
  parameter int unsigned ROWS      = OSD_ROWS,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [2:0]  cmd_len,
  output logic [6:0]  cursor,
  output logic        busy,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_char
);

  localparam logic [6:0] LAST_CELL = 7'(COLS * ROWS - 1);
  localparam logic [6:0] ROW_MASK  = ~7'(COLS - 1);

  state_e      state, state_nx;
  logic [6:0]  clr_cnt;
  logic [31:0] hex_val;
  logic [2:0]  hex_len, hex_k, digit_idx;
  logic        accept, is_nl;
  logic [6:0]  nl_cursor;
  logic        we;
  logic [6:0]  waddr;
  logic [7:0]  wdata;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_nl     = (cmd_data[7:0] == NEWLINE);
  assign nl_cursor = (cursor & ROW_MASK) + 7'(COLS);
  // Digits are emitted most significant first: index n-1-k where n-1 = hex_len.
  assign digit_idx = hex_len - hex_k;

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    waddr    = cursor;
    wdata    = FILL_CHAR;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUTC:  begin
              we    = !is_nl;
              wdata = cmd_data[7:0];
            end
            OP_HEX:   state_nx = ST_HEX;
            OP_CLEAR: state_nx = ST_CLEAR;
            default:  ;
          endcase
        end
      end
      ST_HEX: begin
        we    = 1'b1;
        wdata = hex_ascii(hex_val[{digit_idx, 2'b00} +: 4]);
        if (hex_k == hex_len) state_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        if (clr_cnt == LAST_CELL) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      cursor  <= '0;
      hex_val <= '0;
      hex_len <= '0;
      hex_k   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_PUTC:   cursor <= is_nl ? nl_cursor : cursor + 7'd1;
              OP_SETPOS: cursor <= cmd_data[6:0];
              OP_HEX: begin
                hex_val <= cmd_data;
                hex_len <= cmd_len;
                hex_k   <= '0;
              end
              OP_CLEAR: begin
                clr_cnt <= '0;
                cursor  <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_HEX: begin
          cursor <= cursor + 7'd1;
          hex_k  <= hex_k + 3'd1;
        end
        ST_CLEAR: clr_cnt <= clr_cnt + 7'd1;
        default: ;
      endcase
    end
  end

  osd_text_ram u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

endmodule

// File: tb/tb_osd_text_writer.sv
// Scoreboard bench for osd_text_writer: a reference model of the buffer and
// cursor queues expected read data, popped when the registered read returns.
module tb_osd_text_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic [2:0]  cmd_len = '0;
  logic [6:0]  cursor;
  logic        busy;
  logic [6:0]  rd_addr = '0;
  logic [7:0]  rd_char;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] ref_mem [0:127];
  int         ref_cur = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  osd_text_writer #(.COLS(16), .ROWS(8), .FILL_CHAR(8'h20)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .cursor    (cursor),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h20;
    ref_cur = 0;
  endtask

  // Drives one command at a negedge and updates the model; leaves cmd_valid high.
  task automatic send(input logic [1:0] op, input logic [31:0] data, input logic [2:0] len);
    logic [3:0] nib;
    check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    case (op)
      2'd0: begin
        if (data[7:0] == 8'h0A) ref_cur = (((ref_cur / 16) + 1) * 16) % 128;
        else begin
          ref_mem[ref_cur] = data[7:0];
          ref_cur = (ref_cur + 1) % 128;
        end
      end
      2'd1: ref_cur = int'(data[6:0]);
      2'd2: begin
        for (int j = int'(len); j >= 0; j--) begin
          nib = 4'((data >> (4 * j)) & 32'hF);
          ref_mem[ref_cur] = (nib < 10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
          ref_cur = (ref_cur + 1) % 128;
        end
      end
      default: model_clear();
    endcase
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic read_cell(input int addr);
    rd_addr = 7'(addr);
    exp_q.push_back(ref_mem[addr]);
    @(negedge clk);
    check($sformatf("cell_%0d", addr), 32'(rd_char), 32'(exp_q.pop_front()));
  endtask

  task automatic verify_all();
    for (int a = 0; a < 128; a++) read_cell(a);
  endtask

  // Counts cycles until cmd_ready rises (bounded) and flags any cycle where busy was low.
  task automatic wait_clear(input string tag);
    int cycles = 0;
    int not_busy = 0;
    while (!cmd_ready && cycles < 300) begin
      if (!busy) not_busy++;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_cycles"}, 32'(cycles), 32'd128);
    check({tag, "_busy_low"}, 32'(not_busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'd0);
    reset = 1'b0;
    model_clear();
    wait_clear("autoclear");
    check("post_clear_busy", 32'(busy), 32'd0);
    verify_all();

    // Consecutive PUTCs wrapping past cell 127
    send(2'd1, 32'd126, 3'd0);
    send(2'd0, 32'h41, 3'd0);
    check("putc_ready_a", 32'(cmd_ready), 32'd1);
    send(2'd0, 32'h42, 3'd0);
    check("putc_ready_b", 32'(cmd_ready), 32'd1);
    send(2'd0, 32'h43, 3'd0);
    idle();
    check("putc_cursor", 32'(cursor), 32'(ref_cur));
    check("putc_cursor_const", 32'(cursor), 32'd1);
    read_cell(126); read_cell(127); read_cell(0);

    // HEX with 4 digits
    begin
      int cnt = 0;
      send(2'd1, 32'd20, 3'd0);
      send(2'd2, 32'hDEADBEEF, 3'd3);
      idle();
      while (busy && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      check("hex_busy_cycles", 32'(cnt), 32'd4);
      check("hex_cursor", 32'(cursor), 32'd24);
      check("hex_ready", 32'(cmd_ready), 32'd1);
      for (int a = 20; a < 24; a++) read_cell(a);
      check("hex_cell_20_const", 32'(ref_mem[20]), 32'h42);
    end

    // Full 8-digit HEX wrapping across 127
    begin
      int cnt = 0;
      send(2'd1, 32'd124, 3'd0);
      send(2'd2, 32'h0123A9F5, 3'd7);
      idle();
      while (busy && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      check("hex8_busy_cycles", 32'(cnt), 32'd8);
      check("hex8_cursor", 32'(cursor), 32'(ref_cur));
      for (int a = 124; a < 128; a++) read_cell(a);
      for (int a = 0; a < 4; a++) read_cell(a);
    end

    // Newlines
    send(2'd1, 32'd117, 3'd0);
    send(2'd0, 32'h0A, 3'd0);
    idle();
    check("nl_row7_cursor", 32'(cursor), 32'd0);
    send(2'd1, 32'd5, 3'd0);
    send(2'd0, 32'h0A, 3'd0);
    idle();
    check("nl_row0_cursor", 32'(cursor), 32'd16);
    verify_all();

    // Read-before-write collision
    send(2'd1, 32'd9, 3'd0);
    idle();
    rd_addr = 7'd9;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h5A);
    send(2'd0, 32'h5A, 3'd0);
    idle();
    check("rbw_old", 32'(rd_char), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("rbw_new", 32'(rd_char), 32'(exp_q.pop_front()));

    // CLEAR aborted by reset, then auto-clear
    send(2'd3, 32'd0, 3'd0);
    idle();
    check("clear_cursor", 32'(cursor), 32'd0);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_clear("reclear");
    check("reclear_cursor", 32'(cursor), 32'd0);
    verify_all();

    // Explicit CLEAR after writes runs to completion
    send(2'd1, 32'd70, 3'd0);
    send(2'd0, 32'h51, 3'd0);
    send(2'd3, 32'd0, 3'd0);
    idle();
    begin
      int cnt = 0;
      while (busy && cnt < 300) begin
        cnt++;
        @(negedge clk);
      end
      check("clear_cycles", 32'(cnt), 32'd128);
    end
    read_cell(70);
    check("clear_cursor_end", 32'(cursor), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/osd_text_writer.md
Name: osd_text_writer

Overview:
- Write side of the 16x8 debug OSD character buffer. The existing pixel renderer reads this buffer through rd_addr/rd_char.
- Accepts commands over a valid/ready interface: clear screen, put character, set cursor, print hex value.
- Converts those commands into character writes in an internal 128x8 dual-port buffer.
- Sits between core debug logic (or a small sequencer) and the OSD renderer, and owns the buffer.

Parameters:
- COLS, 16, characters per row (power of two)
- ROWS, 8, character rows (power of two)
- FILL_CHAR, 8'h20, code written by clear and auto-clear

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  writer can accept a command this cycle
- cmd_op  in  2  0=PUTC, 1=SETPOS, 2=HEX, 3=CLEAR
- cmd_data  in  32  PUTC: [7:0] char; SETPOS: [6:0] cell index; HEX: value
- cmd_len  in  3  HEX only: digit count minus 1 (0..7 gives 1..8 digits)
- cursor  out  7  current cell index, row*COLS+col
- busy  out  1  high while in CLEAR or HEX state
- rd_addr  in  7  renderer read address
- rd_char  out  8  buffer contents at rd_addr, registered

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to CLEAR, clear counter = 0, cursor = 0, cmd_ready = 0, busy = 1, rd_char = 0.
  - Buffer contents are not reset. After reset is released, auto-clear runs: 128 cycles writing FILL_CHAR to cells 0..127, then IDLE.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE). Nothing is latched while cmd_ready=0.
- States:
  - IDLE:
    - PUTC with cmd_data[7:0] != 8'h0A: write that char at cursor, cursor <= cursor+1 (wraps 127 to 0). Stay IDLE, so one command per cycle.
    - PUTC with 8'h0A: no write; cursor <= ((cursor/COLS)+1)*COLS mod 128, so a newline on row 7 goes to cell 0.
    - SETPOS: cursor <= cmd_data[6:0]. Stay IDLE.
    - HEX: latch value, n = cmd_len+1, digit counter k = 0; go to HEX.
    - CLEAR: clear counter = 0; go to CLEAR. Cursor resets to 0 on entry.
  - HEX:
    - Each cycle writes digit value[4*(n-1-k)+:4], most significant selected digit first, at cursor. Then cursor+1 (wrapping) and k+1.
    - Digit to char mapping: 0..9 maps to 8'h30..8'h39; A..F maps to 8'h41..8'h46.
    - After the write with k = n-1, go to IDLE. HEX occupies exactly n cycles, and cmd_ready rises on the cycle after the last write.
  - CLEAR: writes FILL_CHAR at the counter address and increments it. After writing address 127, go to IDLE. Duration is 128 cycles; cursor stays 0.
- Read port:
  - Synchronous, with one clk of latency: rd_char <= mem[rd_addr] every cycle. It has no clock enable, so it is independent of the renderer's pixel_ce.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- Reset asserted mid-HEX or mid-CLEAR: the operation aborts immediately and auto-clear restarts after release. Partial writes may exist until the auto-clear overwrites them.
- Address arithmetic: all 7-bit modulo 128. No bounds errors exist.

Decomposition:
- Package osd_pkg:
  - Opcode constants OP_PUTC / OP_SETPOS / OP_HEX / OP_CLEAR.
  - State encoding ST_IDLE / ST_CLEAR / ST_HEX.
  - OSD_COLS, OSD_ROWS, OSD_CELLS=128.
  - Newline code 8'h0A.
- Sub-module osd_text_ram: 128x8 simple dual-port RAM, one write port and one registered read port, read-before-write. Must infer block RAM or LUTRAM.
- Hex nibble-to-ASCII conversion is a function in osd_pkg.

Test Plan:
- Release reset, hold cmd_valid=0 -> cmd_ready=0 and busy=1 for 128 cycles, then cmd_ready=1; reading addresses 0..127 returns 8'h20 each.
- SETPOS 7'd126, then PUTC 'A','B','C' on consecutive cycles -> cells 126=8'h41, 127=8'h42, 0=8'h43; cursor=1; cmd_ready stays 1 throughout.
- SETPOS 7'd20, then HEX value 32'hDEADBEEF with cmd_len=3 -> cells 20..23 = "BEEF" (42,45,45,46); busy high exactly 4 cycles; cursor=24.
- SETPOS 7'd117 (row 7), PUTC 8'h0A -> no cell changes, cursor=0. SETPOS 7'd5, PUTC 8'h0A -> cursor=16.
- Issue CLEAR, then assert reset after 40 cycles -> cmd_ready=0 immediately; after release, a full 128-cycle clear completes and all cells = 8'h20.
- PUTC 'Z' to cell 9 while rd_addr=9 in the same cycle -> rd_char next cycle shows the old value 8'h20; one cycle later it shows 8'h5A.
